// File: rtl/mux_rr_stream_if.sv
// Bundle for the N:1 packet stream mux: per-channel input streams, mode
// controls, and the single registered output stream.
interface mux_rr_stream_if #(
  parameter int unsigned bw_in = 4,
  parameter int unsigned n_ch  = 4,
  parameter int unsigned sel_w = $clog2(n_ch)
);
  logic                     mode;
  logic [sel_w-1:0]         fix_sel;
  logic [n_ch-1:0]          in_valid;
  logic [n_ch*bw_in-1:0]    in_data;
  logic [n_ch-1:0]          in_last;
  logic [n_ch-1:0]          in_ready;
  logic                     out_valid;
  logic [bw_in-1:0]         out_data;
  logic                     out_last;
  logic [sel_w-1:0]         out_sel;
  logic                     out_ready;
  logic                     busy;

  // Driven by sources/consumer around the mux.
  modport master (
    output mode, fix_sel, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel, busy
  );

  // The mux itself.
  modport slave (
    input  mode, fix_sel, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel, busy
  );
endinterface

// File: rtl/mux_rr_stream.sv
// N-channel to 1 packet stream multiplexer: grants one channel per packet
// (round-robin or fixed select) and forwards beats through one output register.
module mux_rr_stream #(
  parameter int unsigned bw_in = 4,
  parameter int unsigned n_ch  = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux_rr_stream_if.slave bus
);
  localparam int unsigned sel_w = $clog2(n_ch);
  localparam int unsigned pad_w = 1 << sel_w;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state;
  logic [sel_w-1:0]   grant;
  logic [sel_w-1:0]   last_grant;
  logic [sel_w-1:0]   rr_idx;
  logic [sel_w-1:0]   cand;
  logic [sel_w-1:0]   sel_idx;
  logic               rr_hit;
  logic               sel_hit;
  logic               accept;
  logic [pad_w-1:0]   ch_valid;
  logic [pad_w-1:0]   ch_last;
  logic [pad_w-1:0]   rdy;
  logic [bw_in-1:0]   ch_data [pad_w];

  logic               out_valid_q;
  logic [bw_in-1:0]   out_data_q;
  logic               out_last_q;
  logic [sel_w-1:0]   out_sel_q;

  // Pad channel views to a power of two so any index (incl. out-of-range
  // fix_sel) reads a non-requesting channel.
  for (genvar k = 0; k < pad_w; k++) begin : g_ch
    if (k < n_ch) begin : g_used
      assign ch_valid[k] = bus.in_valid[k];
      assign ch_last[k]  = bus.in_last[k];
      assign ch_data[k]  = bus.in_data[k*bw_in +: bw_in];
    end else begin : g_pad
      assign ch_valid[k] = 1'b0;
      assign ch_last[k]  = 1'b0;
      assign ch_data[k]  = '0;
    end
  end

  // Round-robin search; last iteration is closest after last_grant and wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int i = 0; i < int'(n_ch); i++) begin
      cand = sel_w'((int'(last_grant) + int'(n_ch) - i) % int'(n_ch));
      if (ch_valid[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  always_comb begin
    sel_hit = bus.mode ? ch_valid[bus.fix_sel] : rr_hit;
    sel_idx = bus.mode ? bus.fix_sel : rr_idx;
  end

  always_comb begin
    rdy = '0;
    if (state == LOCK) rdy[grant] = ~out_valid_q | bus.out_ready;
  end

  assign accept = (state == LOCK) & ch_valid[grant] & rdy[grant];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= sel_w'(n_ch - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_hit) begin
            grant <= sel_idx;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (accept && ch_last[grant]) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Output stage: load on accept, drain on downstream take, else hold.
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ch_data[grant];
        out_last_q  <= ch_last[grant];
        out_sel_q   <= grant;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = rdy[n_ch-1:0];
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.busy      = (state == LOCK);
endmodule

// File: tb/tb_mux_rr_stream.sv
// Directed bench for mux_rr_stream: queue-based sources feed a 4-channel
// instance; a 6-channel instance covers fixed-select range limits.
module tb_mux_rr_stream;
  localparam int unsigned bw  = 8;
  localparam int unsigned nch = 4;

  typedef struct {
    int cyc;
    int sel;
    int last;
    int data;
  } xfer_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_rr_stream_if #(.bw_in(bw), .n_ch(nch)) bus ();
  mux_rr_stream #(.bw_in(bw), .n_ch(nch)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  mux_rr_stream_if #(.bw_in(4), .n_ch(6)) bus6 ();
  mux_rr_stream #(.bw_in(4), .n_ch(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));

  logic [bw:0] srcq [nch][$];
  xfer_t       outq [$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int ch, input logic [bw-1:0] data, input logic last);
    srcq[ch].push_back({last, data});
  endtask

  task automatic clear_src();
    for (int k = 0; k < nch; k++) srcq[k].delete();
  endtask

  task automatic drive_src();
    logic [nch-1:0]    v;
    logic [nch-1:0]    l;
    logic [nch*bw-1:0] d;
    logic [bw:0]       e;
    v = '0; l = '0; d = '0;
    for (int k = 0; k < nch; k++) begin
      if (srcq[k].size() != 0) begin
        e = srcq[k][0];
        v[k] = 1'b1;
        l[k] = e[bw];
        d[k*bw +: bw] = e[bw-1:0];
      end
    end
    bus.in_valid = v;
    bus.in_last  = l;
    bus.in_data  = d;
  endtask

  // One clock: sample handshakes before the edge, then advance the sources.
  task automatic tick();
    logic [nch-1:0] acc;
    xfer_t x;
    #1;
    acc = bus.in_valid & bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      x.cyc  = cyc;
      x.sel  = int'(bus.out_sel);
      x.last = int'(bus.out_last);
      x.data = int'(bus.out_data);
      outq.push_back(x);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < nch; k++) if (acc[k]) void'(srcq[k].pop_front());
    drive_src();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.mode = 1'b0;
    bus.fix_sel = '0;
    bus.out_ready = 1'b1;
    drive_src();
    bus6.mode = 1'b0;
    bus6.fix_sel = '0;
    bus6.in_valid = '0;
    bus6.in_data = '0;
    bus6.in_last = '0;
    bus6.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
    check("rst_out_sel", 32'(bus.out_sel), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Round robin, 2-beat packets on every channel
    outq.delete();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < nch; k++)
        for (int b = 0; b < 2; b++) push(k, 8'(k*16 + b), b == 1);
    drive_src();
    repeat (30) tick();
    check("rr_count", 32'(outq.size()), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < outq.size()) begin
        check($sformatf("rr_sel%0d", i), 32'(outq[i].sel), 32'((i/2) % 4));
        check($sformatf("rr_data%0d", i), 32'(outq[i].data), 32'(((i/2) % 4)*16 + i % 2));
        check($sformatf("rr_last%0d", i), 32'(outq[i].last), 32'(i % 2));
        if (i > 0)
          check($sformatf("rr_gap%0d", i), 32'(outq[i].cyc - outq[i-1].cyc), (i % 2 == 1) ? 1 : 2);
      end
    end

    // Backpressure mid-packet on ch1
    outq.delete();
    push(1, 8'h0A, 1'b0); push(1, 8'h0B, 1'b0); push(1, 8'h0C, 1'b1);
    drive_src();
    tick(); tick();
    check("bp_first_valid", 32'(bus.out_valid), 1);
    check("bp_first_data", 32'(bus.out_data), 32'h0A);
    check("bp_first_sel", 32'(bus.out_sel), 1);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("bp_hold_data%0d", c), 32'(bus.out_data), 32'h0A);
      check($sformatf("bp_hold_valid%0d", c), 32'(bus.out_valid), 1);
      check($sformatf("bp_in_ready%0d", c), 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    repeat (6) tick();
    check("bp_count", 32'(outq.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < outq.size()) begin
        check($sformatf("bp_data%0d", i), 32'(outq[i].data), 32'(8'h0A + i));
        check($sformatf("bp_last%0d", i), 32'(outq[i].last), (i == 2) ? 1 : 0);
      end
    end

    // Mode switch while ch3 holds the grant
    outq.delete();
    push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b1);
    drive_src();
    tick(); tick();
    check("mc_busy", 32'(bus.busy), 1);
    bus.mode = 1'b1;
    bus.fix_sel = 2'd1;
    push(0, 8'h05, 1'b1);
    push(1, 8'h15, 1'b1);
    drive_src();
    repeat (12) tick();
    check("mc_count", 32'(outq.size()), 4);
    begin
      int es[4];
      int ed[4];
      es = '{3, 3, 3, 1};
      ed = '{'h30, 'h31, 'h32, 'h15};
      for (int i = 0; i < 4; i++) begin
        if (i < outq.size()) begin
          check($sformatf("mc_sel%0d", i), 32'(outq[i].sel), 32'(es[i]));
          check($sformatf("mc_data%0d", i), 32'(outq[i].data), 32'(ed[i]));
        end
      end
    end
    check("mc_idle_busy", 32'(bus.busy), 0);

    // Fixed select on ch2 with all channels requesting
    outq.delete();
    bus.fix_sel = 2'd2;
    push(1, 8'h16, 1'b1);
    push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b1);
    push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b1);
    push(3, 8'h36, 1'b1);
    drive_src();
    repeat (15) tick();
    check("fx_count", 32'(outq.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < outq.size()) begin
        check($sformatf("fx_sel%0d", i), 32'(outq[i].sel), 2);
        check($sformatf("fx_data%0d", i), 32'(outq[i].data), 32'(8'h20 + i % 2));
      end
    end
    check("fx_end_busy", 32'(bus.busy), 0);
    check("fx_end_valid", 32'(bus.out_valid), 0);

    // Single-beat packets on ch0 and ch2
    clear_src();
    bus.mode = 1'b0;
    drive_src();
    tick();
    outq.delete();
    for (int i = 0; i < 4; i++) begin
      push(0, 8'(8'h01 + i), 1'b1);
      push(2, 8'(8'h21 + i), 1'b1);
    end
    drive_src();
    repeat (20) tick();
    check("sb_count", 32'(outq.size()), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < outq.size()) begin
        check($sformatf("sb_sel%0d", i), 32'(outq[i].sel), (i % 2 == 0) ? 0 : 2);
        check($sformatf("sb_last%0d", i), 32'(outq[i].last), 1);
        if (i > 0) check($sformatf("sb_gap%0d", i), 32'(outq[i].cyc - outq[i-1].cyc), 2);
      end
    end

    // Asynchronous reset mid-packet, then restart from ch0
    outq.delete();
    for (int k = 0; k < nch; k++)
      for (int b = 0; b < 2; b++) push(k, 8'(k*16 + b), b == 1);
    drive_src();
    tick(); tick();
    check("ar_pre_valid", 32'(bus.out_valid), 1);
    check("ar_pre_sel", 32'(bus.out_sel), 3);
    #2;
    rst = 1'b1;
    #1;
    check("ar_out_valid", 32'(bus.out_valid), 0);
    check("ar_out_sel", 32'(bus.out_sel), 0);
    check("ar_in_ready", 32'(bus.in_ready), 0);
    check("ar_busy", 32'(bus.busy), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    clear_src();
    for (int k = 0; k < nch; k++) push(k, 8'(8'h40 + k), 1'b1);
    drive_src();
    outq.delete();
    repeat (15) tick();
    check("ar_count", 32'(outq.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < outq.size()) check($sformatf("ar_sel%0d", i), 32'(outq[i].sel), 32'(i));

    // Six-channel instance: idle and out-of-range fixed selects never grant
    bus6.mode = 1'b1;
    bus6.in_data = 24'h654321;
    bus6.in_last = '1;
    bus6.in_valid = 6'b011111;
    bus6.fix_sel = 3'd5;
    repeat (4) @(posedge clk);
    #1;
    check("n6_idle_busy", 32'(bus6.busy), 0);
    check("n6_idle_valid", 32'(bus6.out_valid), 0);
    bus6.in_valid = '1;
    bus6.fix_sel = 3'd6;
    repeat (4) @(posedge clk);
    #1;
    check("n6_oor_busy", 32'(bus6.busy), 0);
    check("n6_oor_valid", 32'(bus6.out_valid), 0);
    bus6.fix_sel = 3'd4;
    @(posedge clk);
    #1;
    check("n6_fix4_busy", 32'(bus6.busy), 1);
    @(posedge clk);
    #1;
    check("n6_fix4_valid", 32'(bus6.out_valid), 1);
    check("n6_fix4_sel", 32'(bus6.out_sel), 4);
    check("n6_fix4_data", 32'(bus6.out_data), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
- Parametrised N-channel to 1 stream multiplexer. It is the sequential successor to the team's combinational 2/3/4:1 muxes.
- Each input channel is a valid/ready stream with packet framing (LAST).
- The block grants one channel per packet, using either round-robin or fixed-select mode, and forwards its beats through one registered output stage.
- It sits between per-channel sources (ADC/sample packers) and a single shared downstream consumer (FIFO/UART/USB TX path).

Parameters:
- bw_in, 4, data bit width per channel
- n_ch, 4, number of input channels (2..16)
- sel_w, $clog2(n_ch), width of channel index (derived; do not override)

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous reset, active-high
- MODE  input  1  0 = round-robin arbitration, 1 = fixed select via FIX_SEL
- FIX_SEL  input  sel_w  channel index used when MODE=1
- IN_VALID  input  n_ch  per-channel beat valid
- IN_DATA  input  n_ch*bw_in  channel k occupies bits [k*bw_in +: bw_in]
- IN_LAST  input  n_ch  per-channel last beat of packet
- IN_READY  output  n_ch  per-channel beat accepted when VALID&READY
- OUT_VALID  output  1  registered output beat valid
- OUT_DATA  output  bw_in  registered output data
- OUT_LAST  output  1  registered output last flag
- OUT_SEL  output  sel_w  index of channel that supplied the current OUT beat
- OUT_READY  input  1  downstream accepts OUT beat when OUT_VALID&OUT_READY
- BUSY  output  1  high while a packet grant is held (state LOCK)

Behaviour:
- Reset (async, RST=1):
  - OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, OUT_SEL=0, BUSY=0, IN_READY=0.
  - State=IDLE.
  - Round-robin pointer LastGrant=n_ch-1, so channel 0 has first priority.
- Reset asserted mid-packet: the packet is abandoned and the output beat is dropped. There is no recovery of partial state. Sources are responsible for re-framing.
- State IDLE:
  - IN_READY all 0.
  - If MODE=0: select the first k with IN_VALID[k]=1, searching from LastGrant+1 upward and wrapping modulo n_ch.
  - If MODE=1: select FIX_SEL only if FIX_SEL<n_ch and IN_VALID[FIX_SEL]=1. If FIX_SEL>=n_ch, no grant ever occurs; the block stays IDLE (out-of-range equivalent of the old 'bz default).
  - On a selection, register Grant=k and go to LOCK at the next edge. This is one bubble cycle per packet.
  - MODE and FIX_SEL are sampled only in IDLE. Changes during LOCK take effect after the current packet.
- State LOCK:
  - BUSY=1.
  - IN_READY[Grant] = ~OUT_VALID | OUT_READY. All other IN_READY bits are 0.
  - On an accepted input beat: OUT_DATA<=IN_DATA[Grant], OUT_LAST<=IN_LAST[Grant], OUT_SEL<=Grant, OUT_VALID<=1. Latency is 1 cycle from input accept to OUT_VALID.
  - Accepted beat with IN_LAST=1: LastGrant<=Grant and go to IDLE.
  - If OUT_VALID&OUT_READY with no new accept: OUT_VALID<=0.
  - The output register holds its value while OUT_VALID&~OUT_READY (no data change while stalled).
- Throughput: 1 beat/cycle inside a packet when OUT_READY=1. There is one idle cycle between packets.
- Input rule: a source must not drop IN_VALID or change IN_DATA/IN_LAST until it has been accepted. The block does not check this.
- Single-beat packets (IN_LAST on the first beat) are legal: IDLE→LOCK→IDLE.
- Channel grant fairness (MODE=0): with all channels continuously requesting, grants rotate 0,1,…,n_ch-1,0.

Test Plan:
- Reset: assert RST asynchronously mid-cycle with all IN_VALID=1 → OUT_VALID=0, OUT_SEL=0, IN_READY=0 immediately. After release, the first grant goes to ch0.
- Round-robin with n_ch=4, MODE=0, all channels sending 2-beat packets with data ch*16+beat, OUT_READY=1 → OUT_SEL sequence 0,0,1,1,2,2,3,3,0…, OUT_LAST on every second beat, one bubble between packets.
- Fixed mode: MODE=1, FIX_SEL=2, ch0..3 all valid → only ch2 packets appear. Set FIX_SEL=5 (n_ch=8, ch5 idle) → BUSY stays 0 and no output.
- Backpressure: hold OUT_READY=0 for 3 cycles mid-packet on ch1 (data 0xA,0xB,0xC) → OUT_DATA holds 0xA, IN_READY[1]=0, and no beat is lost or duplicated after release.
- Mode change during LOCK: switch MODE 0→1 while ch3 is mid-packet → the ch3 packet completes intact, and the next grant follows FIX_SEL.
- Single-beat packets on ch0 and ch2 only → grants alternate 0,2,0,2. Each output beat has OUT_LAST=1 and there are 2 cycles per packet.
